// File: rtl/mux2_rr_arbiter_if.sv
// Request/data/grant bundle between two requesters and the shared 2:1 mux arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;

  modport master (
    output req0, req1, d0, d1,
    input  gnt0, gnt1, sel, q, q_valid
  );

  modport slave (
    input  req0, req1, d0, d1,
    output gnt0, gnt1, sel, q, q_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: grants one requester at a time,
// forces a handoff after MAX_HOLD cycles when the other side waits, registers the selected data.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux2_rr_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    sel_d     = sel_q;
    q_d       = q_q;
    q_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? GRANT0 : GRANT1;
        else if (bus.req0)        state_d = GRANT0;
        else if (bus.req1)        state_d = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0)                        state_d = bus.req1 ? GRANT1 : IDLE;
        else if (bus.req1 && hold_q == HOLD_LAST) state_d = GRANT1;
      end
      GRANT1: begin
        if (!bus.req1)                        state_d = bus.req0 ? GRANT0 : IDLE;
        else if (bus.req0 && hold_q == HOLD_LAST) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    // A change into a grant state restarts the hold window; staying saturates it.
    if (state_d != IDLE && state_d != state_q) begin
      hold_d = '0;
      last_d = (state_d == GRANT1);
    end else if (state_d != IDLE && hold_q != HOLD_LAST) begin
      hold_d = hold_q + CW'(1);
    end

    case (state_d)
      GRANT0:  sel_d = 1'b0;
      GRANT1:  sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase

    if (state_q != IDLE) begin
      q_d       = sel_q ? bus.d1 : bus.d0;
      q_valid_d = 1'b1;
    end
  end

  always_comb begin
    bus.gnt0    = (state_q == GRANT0);
    bus.gnt1    = (state_q == GRANT1);
    bus.sel     = sel_q;
    bus.q       = q_q;
    bus.q_valid = q_valid_q;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share one stimulus stream and are checked against an ownership-level reference model.
module tb_mux2_rr_arbiter;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       s;
    logic [7:0] q;
    logic       qv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  mux2_rr_arbiter_if #(.WIDTH(8)) if0 ();
  mux2_rr_arbiter_if #(.WIDTH(8)) if1 ();

  assign if0.req0 = req0;
  assign if0.req1 = req1;
  assign if0.d0   = d0;
  assign if0.d1   = d1;
  assign if1.req0 = req0;
  assign if1.req1 = req1;
  assign if1.d0   = d0;
  assign if1.d1   = d1;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference model: who owns the channel, for how many cycles, and who had it last.
  int         owner[2];
  int         run[2];
  int         lastw[2];
  logic       selm[2];
  logic [7:0] qm[2];
  logic       qvm[2];
  int         maxh[2];

  function automatic exp_t model_step(int k, bit r, bit r0, bit r1, logic [7:0] a, logic [7:0] b);
    int   nxt;
    bit   rx, ry;
    exp_t e;
    if (r) begin
      owner[k] = -1;
      run[k]   = 0;
      lastw[k] = 1;
      selm[k]  = 1'b0;
      qm[k]    = 8'h00;
      qvm[k]   = 1'b0;
    end else begin
      if (owner[k] == -1) begin
        if (r0 && r1)  nxt = 1 - lastw[k];
        else if (r0)   nxt = 0;
        else if (r1)   nxt = 1;
        else           nxt = -1;
      end else begin
        rx = (owner[k] == 1) ? r1 : r0;
        ry = (owner[k] == 1) ? r0 : r1;
        if (!rx)                        nxt = ry ? 1 - owner[k] : -1;
        else if (ry && run[k] >= maxh[k]) nxt = 1 - owner[k];
        else                            nxt = owner[k];
      end
      if (owner[k] != -1) begin
        qm[k]  = (owner[k] == 1) ? b : a;
        qvm[k] = 1'b1;
      end else begin
        qvm[k] = 1'b0;
      end
      if (nxt != -1) begin
        selm[k] = (nxt == 1);
        if (nxt != owner[k]) begin
          run[k]   = 1;
          lastw[k] = nxt;
        end else begin
          run[k] = run[k] + 1;
        end
      end
      owner[k] = nxt;
    end
    e.g0 = (owner[k] == 0);
    e.g1 = (owner[k] == 1);
    e.s  = selm[k];
    e.q  = qm[k];
    e.qv = qvm[k];
    return e;
  endfunction

  task automatic drive(bit r, bit r0, bit r1, logic [7:0] a, logic [7:0] b);
    @(negedge clk);
    rst  = r;
    req0 = r0;
    req1 = r1;
    d0   = a;
    d1   = b;
    sb0.push_back(model_step(0, r, r0, r1, a, b));
    sb1.push_back(model_step(1, r, r0, r1, a, b));
  endtask

  task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL dut%0d cyc=%0d %s got=%0h exp=%0h", k, cyc, nm, act, exp);
    end
  endtask

  task automatic cmp(int k, exp_t e, logic g0, logic g1, logic s, logic [7:0] q, logic qv);
    chk(k, "gnt0", 32'(g0), 32'(e.g0));
    chk(k, "gnt1", 32'(g1), 32'(e.g1));
    chk(k, "sel", 32'(s), 32'(e.s));
    chk(k, "q", 32'(q), 32'(e.q));
    chk(k, "q_valid", 32'(qv), 32'(e.qv));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        cmp(0, e, if0.gnt0, if0.gnt1, if0.sel, if0.q, if0.q_valid);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        cmp(1, e, if1.gnt0, if1.gnt1, if1.sel, if1.q, if1.q_valid);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit r, r0, r1;
    maxh[0] = 4;
    maxh[1] = 1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;

    // Reset held two edges with both requesting.
    repeat (2) drive(1, 1, 1, 8'($urandom), 8'($urandom));
    // Lone requester 0 with fixed data.
    repeat (2) drive(0, 1, 0, 8'hA5, 8'($urandom));
    // Both requesting from reset: round-robin with hold limit.
    drive(1, 1, 1, 8'($urandom), 8'($urandom));
    repeat (20) drive(0, 1, 1, 8'($urandom), 8'($urandom));
    // Requester 0 drops while 1 waits: handoff without an idle gap.
    drive(1, 0, 0, 8'($urandom), 8'($urandom));
    repeat (2) drive(0, 1, 0, 8'($urandom), 8'($urandom));
    repeat (2) drive(0, 0, 1, 8'($urandom), 8'($urandom));
    // Reset during GRANT1, then contention goes to requester 0.
    drive(1, 1, 1, 8'($urandom), 8'($urandom));
    repeat (3) drive(0, 1, 1, 8'($urandom), 8'($urandom));
    // From GRANT1 drop everything: q keeps last d1, sel stays 1.
    repeat (3) drive(0, 0, 1, 8'($urandom), 8'h3C);
    repeat (3) drive(0, 0, 0, 8'($urandom), 8'($urandom));
    // Lone requester saturates its counter and is never preempted, then contention.
    repeat (8) drive(0, 1, 0, 8'($urandom), 8'($urandom));
    repeat (3) drive(0, 1, 1, 8'($urandom), 8'($urandom));

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      drive(r, r0, r1, 8'($urandom), 8'($urandom));
    end

    drive(0, 0, 0, 8'($urandom), 8'($urandom));
    for (int w = 0; w < 10 && (sb0.size() > 0 || sb1.size() > 0); w++) @(posedge clk);
    @(negedge clk);
    if (sb0.size() > 0 || sb1.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
